instruction_encoder_loader: RTL and testbench
=============================================

Name: instruction_encoder_loader

Overview:
- Inverse of the instruction decoder: accepts decoded instruction fields over a valid/ready stream and packs them into 16-bit instruction words.
- Range-checks immediates and writes the packed words into instruction memory at consecutive addresses starting from a programmable base.
- Used by the test/boot path to load programs into the RISC machine's instruction RAM.

Parameters:
- ADDR_W, 8: instruction memory address width; top address is all-ones (2**ADDR_W-1).

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-high reset.
- start  input  1  one-cycle pulse; begins a load session at base_addr.
- base_addr  input  ADDR_W  first write address, sampled with start.
- in_valid  input  1  field bundle valid.
- in_ready  output  1  encoder can accept a bundle this cycle.
- opcode  input  3  instruction opcode.
- op  input  2  sub-operation.
- rn, rd, rm  input  3 each  register numbers.
- shift  input  2  shift code.
- imm  input  16  two's-complement immediate, already sign-extended to 16 bits.
- last  input  1  bundle is the final instruction of the session.
- mem_write  output  1  one-cycle write strobe to instruction memory.
- mem_addr  output  ADDR_W  write address.
- mem_dout  output  16  encoded instruction word.
- count  output  ADDR_W+1  words written this session.
- done  output  1  session completed normally; sticky.
- err  output  1  session aborted; sticky.
- err_code  output  2  01 illegal opcode/op, 10 immediate out of range, 11 address overflow.

Behaviour:
- Reset: state IDLE. All outputs are 0, including in_ready, mem_write, mem_addr, mem_dout, count, done, err and err_code.
- All outputs are registered.
- States:
  - IDLE: in_ready=0. start -> ACCEPT; clears done, err, err_code and count; loads the address pointer with base_addr.
  - ACCEPT: in_ready=1. A handshake is in_valid&in_ready.
    - Legal bundle on handshake: register the word into mem_dout and the pointer into mem_addr; next state WRITE.
    - Illegal bundle on handshake: next state ERROR with the matching err_code; no write is issued.
  - WRITE: mem_write=1 for exactly this cycle; in_ready=0; count increments.
    - If last was set on the bundle -> DONE.
    - Else if the pointer equals all-ones -> ERROR, err_code=11. The pointer never wraps.
    - Else pointer+1 -> ACCEPT.
  - DONE: done=1. start restarts the session as from IDLE.
  - ERROR: err=1, err_code held. start restarts the session as from IDLE.
- start is ignored in ACCEPT and WRITE.
- Latency: handshake in cycle N -> mem_write in cycle N+1. Maximum throughput is 1 word per 2 cycles.
- Encoding, msb first; fields not listed are ignored:
  - opcode=110, op=10 (MOV imm): {110,10,rn,imm[7:0]}. Legal iff imm[15:7] are all equal (range -128..127).
  - opcode=110, op=00 (MOV reg): {110,00,000,rd,shift,rm}.
  - opcode=101, any op (ALU): {101,op,rn,rd,shift,rm}.
  - opcode=011 or 100, op=00 (LDR/STR): {opcode,00,rn,rd,imm[4:0]}. Legal iff imm[15:4] are all equal (range -16..15).
  - opcode=111 (HALT): {111,13'b0}; op is ignored.
  - Any other opcode/op combination: err_code=01.
- Error priority: illegal opcode/op is checked before immediate range.
- Reset asserted mid-session aborts immediately. A write strobe in flight is dropped, and all outputs return to 0.

Test Plan:
1. MOV imm: start with base_addr=8'h10. Send MOV R0,#7 then MOV R1,#-1 (imm=16'hFFFF, last=1).
   -> mem_dout=16'hD007 @10, then 16'hD1FF @11.
   -> done=1, count=2, exactly 2 single-cycle mem_write pulses.
2. ALU and MOV reg:
   -> ALU opcode=101 op=00 rn=1 rd=2 shift=01 rm=0 gives 16'hA148.
   -> MOV reg rd=3 rm=2 shift=00 gives 16'hC062.
   -> Hold in_valid high continuously and check that in_ready toggles 1,0,1,0.
3. LDR imm5: opcode=011 rn=5 rd=4 imm=16'hFFFE -> 16'h659E. With imm=16'h0010 -> err=1, err_code=10, no mem_write.
4. MOV imm out of range: imm=16'h00C8 -> err_code=10, no write. Illegal opcode=000 -> err_code=01. In both cases the next start clears err.
5. Overflow: base_addr=8'hFF with a non-last bundle -> one write @FF, then err=1, err_code=11, count=1.
6. Reset mid-session: assert reset in the WRITE cycle -> mem_write and all outputs 0 asynchronously, state IDLE. A subsequent start plus a bundle writes correctly from the new base.

Source files
------------

// File: rtl/instruction_encoder_loader.sv
// Packs decoded instruction fields into 16-bit words and streams them into instruction RAM
// at consecutive addresses from a programmable base; one word per two cycles, sticky done/err.
module instruction_encoder_loader #(
   parameter int ADDR_W = 8
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic [ADDR_W-1:0] base_addr,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [2:0]        opcode,
   input  logic [1:0]        op,
   input  logic [2:0]        rn,
   input  logic [2:0]        rd,
   input  logic [2:0]        rm,
   input  logic [1:0]        shift,
   input  logic [15:0]       imm,
   input  logic              last,
   output logic              mem_write,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [15:0]       mem_dout,
   output logic [ADDR_W:0]   count,
   output logic              done,
   output logic              err,
   output logic [1:0]        err_code
);

   // One-hot so every status output decodes from a single state flop.
   typedef enum logic [4:0] {
      S_IDLE   = 5'b00001,
      S_ACCEPT = 5'b00010,
      S_WRITE  = 5'b00100,
      S_DONE   = 5'b01000,
      S_ERROR  = 5'b10000
   } state_t;

   localparam logic [1:0] CODE_OK       = 2'b00;
   localparam logic [1:0] CODE_ILLEGAL  = 2'b01;
   localparam logic [1:0] CODE_RANGE    = 2'b10;
   localparam logic [1:0] CODE_OVERFLOW = 2'b11;

   state_t            state;
   state_t            state_next;
   logic [ADDR_W-1:0] ptr;
   logic              last_q;
   logic [15:0]       enc_word;
   logic [1:0]        enc_code;
   logic              handshake;
   logic              session_start;
   logic              ptr_at_top;

   assign handshake     = (state == S_ACCEPT) && in_valid;
   assign session_start = start && ((state == S_IDLE) || (state == S_DONE) || (state == S_ERROR));
   assign ptr_at_top    = (ptr == {ADDR_W{1'b1}});

   // Field packing; opcode/op legality is resolved before the immediate range check.
   always_comb begin
      enc_word = 16'h0000;
      enc_code = CODE_OK;
      case (opcode)
         3'b110: begin
            if (op == 2'b10) begin
               enc_word = {3'b110, 2'b10, rn, imm[7:0]};
               if (!((&imm[15:7]) || (~|imm[15:7])))
                  enc_code = CODE_RANGE;
            end else if (op == 2'b00) begin
               enc_word = {3'b110, 2'b00, 3'b000, rd, shift, rm};
            end else begin
               enc_code = CODE_ILLEGAL;
            end
         end
         3'b101: begin
            enc_word = {3'b101, op, rn, rd, shift, rm};
         end
         3'b011, 3'b100: begin
            if (op == 2'b00) begin
               enc_word = {opcode, 2'b00, rn, rd, imm[4:0]};
               if (!((&imm[15:4]) || (~|imm[15:4])))
                  enc_code = CODE_RANGE;
            end else begin
               enc_code = CODE_ILLEGAL;
            end
         end
         3'b111: begin
            enc_word = {3'b111, 13'b0};
         end
         default: begin
            enc_code = CODE_ILLEGAL;
         end
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         state <= S_IDLE;
      else
         state <= state_next;
   end

   always_comb begin
      state_next = state;
      case (state)
         S_IDLE:   if (start) state_next = S_ACCEPT;
         S_ACCEPT: begin
            if (in_valid)
               state_next = (enc_code == CODE_OK) ? S_WRITE : S_ERROR;
         end
         S_WRITE: begin
            if (last_q)
               state_next = S_DONE;
            else if (ptr_at_top)
               state_next = S_ERROR;
            else
               state_next = S_ACCEPT;
         end
         S_DONE:   if (start) state_next = S_ACCEPT;
         S_ERROR:  if (start) state_next = S_ACCEPT;
         default:  state_next = S_IDLE;
      endcase
   end

   always_comb begin
      in_ready  = (state == S_ACCEPT);
      mem_write = (state == S_WRITE);
      done      = (state == S_DONE);
      err       = (state == S_ERROR);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         ptr      <= '0;
         last_q   <= 1'b0;
         mem_addr <= '0;
         mem_dout <= 16'h0000;
         count    <= '0;
         err_code <= CODE_OK;
      end else begin
         if (session_start) begin
            ptr      <= base_addr;
            count    <= '0;
            err_code <= CODE_OK;
         end
         if (handshake) begin
            if (enc_code == CODE_OK) begin
               mem_dout <= enc_word;
               mem_addr <= ptr;
               last_q   <= last;
            end else begin
               err_code <= enc_code;
            end
         end
         // The pointer saturates at the top address; running past it is an overflow abort.
         if (state == S_WRITE) begin
            count <= count + {{ADDR_W{1'b0}}, 1'b1};
            if (!last_q) begin
               if (ptr_at_top)
                  err_code <= CODE_OVERFLOW;
               else
                  ptr <= ptr + {{(ADDR_W-1){1'b0}}, 1'b1};
            end
         end
      end
   end

endmodule

// File: tb/tb_instruction_encoder_loader.sv
// Randomized and directed bench for instruction_encoder_loader against a session-level reference model.
module tb_instruction_encoder_loader;

   localparam int TOP = 255;

   logic        clk = 1'b0;
   logic        reset, start, in_valid, last;
   logic [7:0]  base_addr;
   logic [2:0]  opcode, rn, rd, rm;
   logic [1:0]  op, shift;
   logic [15:0] imm;
   wire         in_ready, mem_write, done, err;
   wire  [7:0]  mem_addr;
   wire  [15:0] mem_dout;
   wire  [8:0]  count;
   wire  [1:0]  err_code;

   instruction_encoder_loader #(.ADDR_W(8)) dut (
      .clk(clk), .reset(reset), .start(start), .base_addr(base_addr),
      .in_valid(in_valid), .in_ready(in_ready), .opcode(opcode), .op(op),
      .rn(rn), .rd(rd), .rm(rm), .shift(shift), .imm(imm), .last(last),
      .mem_write(mem_write), .mem_addr(mem_addr), .mem_dout(mem_dout),
      .count(count), .done(done), .err(err), .err_code(err_code)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Scoreboard: {addr, data} of every write seen and every write the model predicts.
   logic [23:0] got_q[$];
   logic [23:0] exp_q[$];
   logic        mw_prev = 1'b0;

   always @(negedge clk) begin
      if (mem_write) begin
         got_q.push_back({mem_addr, mem_dout});
         check_eq("write_pulse_single", {31'b0, mw_prev}, 0);
      end
      mw_prev = mem_write;
   end

   int m_ptr, m_cnt, m_code;
   bit m_end, m_done;

   task automatic model_start(input logic [7:0] b);
      m_ptr = b; m_cnt = 0; m_code = 0; m_end = 0; m_done = 0;
   endtask

   task automatic model_encode(input logic [2:0] oc, input logic [1:0] o, input logic [2:0] n,
                               input logic [2:0] d, input logic [2:0] m, input logic [1:0] sh,
                               input logic [15:0] im, output int code, output int word);
      int si;
      si = int'($signed(im));
      code = 0;
      word = 0;
      if (oc == 6 && o == 2) begin
         if (si < -128 || si > 127) code = 2;
         word = 6*8192 + 2*2048 + int'(n)*256 + (si & 255);
      end else if (oc == 6 && o == 0) begin
         word = 6*8192 + int'(d)*32 + int'(sh)*8 + int'(m);
      end else if (oc == 5) begin
         word = 5*8192 + int'(o)*2048 + int'(n)*256 + int'(d)*32 + int'(sh)*8 + int'(m);
      end else if ((oc == 3 || oc == 4) && o == 0) begin
         if (si < -16 || si > 15) code = 2;
         word = int'(oc)*8192 + int'(n)*256 + int'(d)*32 + (si & 31);
      end else if (oc == 7) begin
         word = 7*8192;
      end else begin
         code = 1;
      end
   endtask

   task automatic model_bundle(input logic [2:0] oc, input logic [1:0] o, input logic [2:0] n,
                               input logic [2:0] d, input logic [2:0] m, input logic [1:0] sh,
                               input logic [15:0] im, input logic lst);
      int code, word;
      if (m_end) return;
      model_encode(oc, o, n, d, m, sh, im, code, word);
      if (code != 0) begin
         m_end = 1; m_code = code;
         return;
      end
      exp_q.push_back({8'(m_ptr), 16'(word)});
      m_cnt++;
      if (lst) begin
         m_end = 1; m_done = 1;
      end else if (m_ptr == TOP) begin
         m_end = 1; m_code = 3;
      end else begin
         m_ptr++;
      end
   endtask

   task automatic pulse_start(input logic [7:0] b);
      @(posedge clk); #1;
      start = 1'b1; base_addr = b;
      @(posedge clk); #1;
      start = 1'b0;
      model_start(b);
   endtask

   task automatic send(input logic [2:0] oc, input logic [1:0] o, input logic [2:0] n,
                       input logic [2:0] d, input logic [2:0] m, input logic [1:0] sh,
                       input logic [15:0] im, input logic lst);
      logic rdy;
      bit   ok;
      ok = 0;
      opcode = oc; op = o; rn = n; rd = d; rm = m; shift = sh; imm = im; last = lst;
      in_valid = 1'b1;
      for (int t = 0; t < 20 && !ok; t++) begin
         @(negedge clk); rdy = in_ready;
         @(posedge clk); #1;
         if (rdy) ok = 1;
      end
      in_valid = 1'b0;
      if (!ok) check_eq("handshake_timeout", 0, 1);
      model_bundle(oc, o, n, d, m, sh, im, lst);
   endtask

   task automatic settle();
      repeat (3) @(posedge clk);
      #1;
   endtask

   task automatic end_session(input string tag);
      settle();
      check_eq({tag, "_nwr"}, got_q.size(), exp_q.size());
      while (got_q.size() > 0 && exp_q.size() > 0)
         check_eq({tag, "_wr"}, got_q.pop_front(), exp_q.pop_front());
      got_q.delete();
      exp_q.delete();
      check_eq({tag, "_done"}, {31'b0, done}, {31'b0, m_done});
      check_eq({tag, "_err"}, {31'b0, err}, (m_code != 0) ? 1 : 0);
      check_eq({tag, "_code"}, {30'b0, err_code}, m_code);
      check_eq({tag, "_count"}, {23'b0, count}, m_cnt);
   endtask

   task automatic rand_bundle(output logic [2:0] oc, output logic [1:0] o, output logic [2:0] n,
                              output logic [2:0] d, output logic [2:0] m, output logic [1:0] sh,
                              output logic [15:0] im);
      int r;
      n = 3'($urandom); d = 3'($urandom); m = 3'($urandom); sh = 2'($urandom);
      o = 2'($urandom); oc = 3'($urandom);
      case ($urandom_range(0, 6))
         0: begin oc = 3'd6; o = 2'd2; end
         1: begin oc = 3'd6; o = 2'd0; end
         2: oc = 3'd5;
         3: begin oc = ($urandom_range(0, 1) == 0) ? 3'd3 : 3'd4; o = 2'd0; end
         4: oc = 3'd7;
         5: oc = 3'($urandom_range(0, 2));
         default: ;
      endcase
      case ($urandom_range(0, 2))
         0: im = 16'($urandom);
         1: begin r = int'($urandom_range(0, 63)) - 32; im = 16'(r); end
         default: begin r = int'($urandom_range(0, 319)) - 160; im = 16'(r); end
      endcase
   endtask

   logic [2:0]  g_oc, g_n, g_d, g_m;
   logic [1:0]  g_o, g_sh;
   logic [15:0] g_im;
   int          nb;
   bit          seen;

   initial begin
      #300000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   initial begin
      reset = 1'b1; start = 1'b0; in_valid = 1'b0; last = 1'b0; base_addr = 8'h00;
      opcode = 3'd0; op = 2'd0; rn = 3'd0; rd = 3'd0; rm = 3'd0; shift = 2'd0; imm = 16'h0;
      repeat (2) @(posedge clk);
      #1;
      check_eq("rst_ctrl", {26'b0, in_ready, mem_write, done, err, err_code}, 0);
      check_eq("rst_addr", {24'b0, mem_addr}, 0);
      check_eq("rst_dout", {16'b0, mem_dout}, 0);
      check_eq("rst_count", {23'b0, count}, 0);
      reset = 1'b0;
      @(posedge clk); #1;
      check_eq("idle_not_ready", {31'b0, in_ready}, 0);

      // MOV immediate pair from base 0x10.
      pulse_start(8'h10);
      send(3'd6, 2'd2, 3'd0, 3'd0, 3'd0, 2'd0, 16'h0007, 1'b0);
      send(3'd6, 2'd2, 3'd1, 3'd0, 3'd0, 2'd0, 16'hFFFF, 1'b1);
      settle();
      check_eq("t1_w0", (got_q.size() > 0) ? {8'b0, got_q[0]} : 32'hFFFFFFFF, 32'h0010D007);
      check_eq("t1_w1", (got_q.size() > 1) ? {8'b0, got_q[1]} : 32'hFFFFFFFF, 32'h0011D1FF);
      end_session("t1");

      // Back-to-back with in_valid held high: in_ready alternates.
      pulse_start(8'h20);
      opcode = 3'd5; op = 2'd0; rn = 3'd1; rd = 3'd2; shift = 2'd1; rm = 3'd0; imm = 16'h0; last = 1'b0;
      in_valid = 1'b1;
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         check_eq($sformatf("t2_rdy%0d", k), {31'b0, in_ready}, (k % 2 == 0) ? 1 : 0);
         if (k == 1) begin
            opcode = 3'd6; op = 2'd0; rn = 3'd0; rd = 3'd3; shift = 2'd0; rm = 3'd2; last = 1'b1;
         end
      end
      in_valid = 1'b0;
      model_bundle(3'd5, 2'd0, 3'd1, 3'd2, 3'd0, 2'd1, 16'h0, 1'b0);
      model_bundle(3'd6, 2'd0, 3'd0, 3'd3, 3'd2, 2'd0, 16'h0, 1'b1);
      settle();
      check_eq("t2_w0", (got_q.size() > 0) ? {8'b0, got_q[0]} : 32'hFFFFFFFF, 32'h0020A148);
      check_eq("t2_w1", (got_q.size() > 1) ? {8'b0, got_q[1]} : 32'hFFFFFFFF, 32'h0021C062);
      end_session("t2");

      // LDR in range, then out of range.
      pulse_start(8'h30);
      send(3'd3, 2'd0, 3'd5, 3'd4, 3'd0, 2'd0, 16'hFFFE, 1'b0);
      send(3'd3, 2'd0, 3'd1, 3'd1, 3'd0, 2'd0, 16'h0010, 1'b1);
      settle();
      check_eq("t3_w0", (got_q.size() > 0) ? {8'b0, got_q[0]} : 32'hFFFFFFFF, 32'h0030659E);
      check_eq("t3_code", {30'b0, err_code}, 2);
      end_session("t3");

      // Error aborts, each cleared by the next start.
      pulse_start(8'h40);
      send(3'd6, 2'd2, 3'd2, 3'd0, 3'd0, 2'd0, 16'h00C8, 1'b1);
      end_session("t4a");
      pulse_start(8'h40);
      check_eq("t4_clr_a", {29'b0, err, err_code}, 0);
      send(3'd0, 2'd0, 3'd0, 3'd0, 3'd0, 2'd0, 16'h0, 1'b1);
      end_session("t4b");
      check_eq("t4b_code", {30'b0, err_code}, 1);
      pulse_start(8'h50);
      check_eq("t4_clr_b", {29'b0, err, err_code}, 0);
      send(3'd7, 2'd3, 3'd0, 3'd0, 3'd0, 2'd0, 16'h0, 1'b1);
      end_session("t4c");

      // Address overflow at the top of memory.
      pulse_start(8'hFF);
      send(3'd5, 2'd1, 3'd1, 3'd2, 3'd3, 2'd1, 16'h0, 1'b0);
      end_session("t5");
      check_eq("t5_code", {30'b0, err_code}, 3);
      check_eq("t5_count", {23'b0, count}, 1);

      // Reset in the middle of a write cycle.
      pulse_start(8'h60);
      opcode = 3'd5; op = 2'd1; rn = 3'd2; rd = 3'd3; rm = 3'd4; shift = 2'd2; last = 1'b0;
      in_valid = 1'b1;
      seen = 0;
      for (int t = 0; t < 20 && !seen; t++) begin
         @(negedge clk);
         if (mem_write) seen = 1;
      end
      check_eq("t6_write_seen", {31'b0, seen}, 1);
      #2 reset = 1'b1;
      #1;
      check_eq("t6_rst_ctrl", {26'b0, in_ready, mem_write, done, err, err_code}, 0);
      check_eq("t6_rst_count", {23'b0, count}, 0);
      check_eq("t6_rst_dout", {16'b0, mem_dout}, 0);
      in_valid = 1'b0;
      @(posedge clk); #1;
      reset = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check_eq("t6_idle", {30'b0, in_ready, mem_write}, 0);
      got_q.delete();
      exp_q.delete();
      pulse_start(8'h70);
      send(3'd5, 2'd2, 3'd7, 3'd6, 3'd5, 2'd3, 16'h0, 1'b1);
      end_session("t6");

      // Randomized sessions, some starting near the top address.
      for (int s = 0; s < 40; s++) begin
         pulse_start(($urandom_range(0, 3) == 0) ? 8'($urandom_range(250, 255)) : 8'($urandom));
         nb = int'($urandom_range(1, 6));
         for (int i = 0; i < nb && !m_end; i++) begin
            rand_bundle(g_oc, g_o, g_n, g_d, g_m, g_sh, g_im);
            send(g_oc, g_o, g_n, g_d, g_m, g_sh, g_im, (i == nb - 1) ? 1'b1 : 1'b0);
         end
         end_session("rnd");
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
